seg7_mux_decoder: RTL and testbench

SEG7_MUX_DECODER -- requirements
Module: seg7_mux_decoder

---
 rtl/seg7_mux_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_seg7_mux_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_mux_decoder
//  Purpose  : Snoops a two-digit multiplexed 7-segment display bus and
//             recovers the displayed number. Segment and strobe lines are
//             synchronized, and a digit is captured only after the bus has
//             held still for STABLE_CYCLES consecutive synchronized samples.
//             Captured digits are decoded to BCD and combined into a binary
//             value. Loss of strobes for TIMEOUT_CYCLES drops the link.
//  Ports    :
//    clk        in   1  rising-edge clock
//    rst        in   1  asynchronous active-high reset
//    seg_in     in   7  segments {g,f,e,d,c,b,a}, active-high, async to clk
//    dig_in     in   2  digit strobes, bit0 = ones, bit1 = tens, async
//    ones_out   out  4  last decoded ones digit (BCD)
//    tens_out   out  4  last decoded tens digit (BCD)
//    value_out  out  7  tens*10 + ones
//    valid      out  1  both digits captured since reset/timeout
//    update     out  1  one-cycle pulse when value_out changes while valid
//    seg_err    out  1  sticky illegal-pattern / illegal-strobe flag
//    timeout    out  1  link-lost flag
//  Revision : 1.0  initial release
// ============================================================================
module seg7_mux_decoder #(
  parameter int STABLE_CYCLES  = 4,     // 2..255
  parameter int TIMEOUT_CYCLES = 4096   // 16..65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_in,
  output logic [3:0] ones_out,
  output logic [3:0] tens_out,
  output logic [6:0] value_out,
  output logic       valid,
  output logic       update,
  output logic       seg_err,
  output logic       timeout
);

  // Stability counter saturates at STABLE_CYCLES; a capture fires on the
  // cycle it would step from STABLE_CYCLES-1 to STABLE_CYCLES.
  localparam logic [7:0]  c_STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0]  c_STAB_TGT = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] c_TO_MAX   = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] c_TO_TGT   = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0]  c_PH_ONES  = 2'b01;
  localparam logic [1:0]  c_PH_TENS  = 2'b10;
  localparam logic [1:0]  c_PH_ILL   = 2'b11;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers plus a one-cycle history for change detection
  // --------------------------------------------------------------------------
  logic [6:0]  r_seg_s1, r_seg_sync, r_seg_prev;
  logic [1:0]  r_dig_s1, r_dig_sync, r_dig_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1   <= '0;
      r_seg_sync <= '0;
      r_seg_prev <= '0;
      r_dig_s1   <= '0;
      r_dig_sync <= '0;
      r_dig_prev <= '0;
    end else begin
      r_seg_s1   <= seg_in;
      r_seg_sync <= r_seg_s1;
      r_seg_prev <= r_seg_sync;
      r_dig_s1   <= dig_in;
      r_dig_sync <= r_dig_s1;
      r_dig_prev <= r_dig_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Segment pattern decode
  // --------------------------------------------------------------------------
  logic [3:0] w_digit;
  logic       w_legal;
  logic       w_blank;

  always_comb begin
    w_digit = 4'd0;
    w_legal = 1'b1;
    case (r_seg_sync)
      7'h3F:   w_digit = 4'd0;
      7'h06:   w_digit = 4'd1;
      7'h5B:   w_digit = 4'd2;
      7'h4F:   w_digit = 4'd3;
      7'h66:   w_digit = 4'd4;
      7'h6D:   w_digit = 4'd5;
      7'h7D:   w_digit = 4'd6;
      7'h07:   w_digit = 4'd7;
      7'h7F:   w_digit = 4'd8;
      7'h6F:   w_digit = 4'd9;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_blank = (r_seg_sync == 7'h00);

  // --------------------------------------------------------------------------
  // Stability window and capture events
  // --------------------------------------------------------------------------
  logic [7:0]  r_stab_cnt;
  logic        w_same;
  logic        w_reach;
  logic        w_ph_ones;
  logic        w_ph_tens;
  logic        w_cap;
  logic        w_cap_legal;
  logic        w_cap_bad;
  logic        w_strobe_err;

  assign w_same       = (r_seg_sync == r_seg_prev) && (r_dig_sync == r_dig_prev);
  // Equality with STABLE_CYCLES-1 (not STABLE_CYCLES) makes the event a
  // single-cycle one: once saturated the counter never re-enters this value
  // until the bus changes.
  assign w_reach      = w_same && (r_stab_cnt == c_STAB_TGT);
  assign w_ph_ones    = (r_dig_sync == c_PH_ONES);
  assign w_ph_tens    = (r_dig_sync == c_PH_TENS);
  assign w_cap        = w_reach && (w_ph_ones || w_ph_tens);
  assign w_cap_legal  = w_cap && w_legal;
  assign w_cap_bad    = w_cap && !w_legal && !w_blank;
  assign w_strobe_err = w_reach && (r_dig_sync == c_PH_ILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stab_cnt <= '0;
    end else if (!w_same) begin
      r_stab_cnt <= '0;
    end else if (r_stab_cnt != c_STAB_MAX) begin
      r_stab_cnt <= r_stab_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Link timeout; any capture (legal, blank or bad) proves the link is alive
  // and takes priority over a coincident expiry.
  // --------------------------------------------------------------------------
  logic [15:0] r_to_cnt;
  logic        w_to_fire;

  assign w_to_fire = !w_cap && (r_to_cnt == c_TO_TGT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_cap) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_TO_MAX) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit registers, seen flags and status flags
  // --------------------------------------------------------------------------
  logic [3:0] r_ones, r_tens;
  logic       r_seen_ones, r_seen_tens;
  logic       r_seg_err, r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones      <= '0;
      r_tens      <= '0;
      r_seen_ones <= 1'b0;
      r_seen_tens <= 1'b0;
    end else if (w_cap_legal) begin
      if (w_ph_ones) begin
        r_ones      <= w_digit;
        r_seen_ones <= 1'b1;
      end else begin
        r_tens      <= w_digit;
        r_seen_tens <= 1'b1;
      end
    end else if (w_to_fire) begin
      // Digits are held; only the "seen" state is forgotten.
      r_seen_ones <= 1'b0;
      r_seen_tens <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_err <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_cap_bad || w_strobe_err) begin
        r_seg_err <= 1'b1;
      end
      if (w_cap) begin
        r_timeout <= 1'b0;
      end else if (w_to_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Binary value, valid and update pulse. value_out follows a digit load by
  // one edge; valid follows the seen flags by one edge, so both settle on
  // the same edge and update can be judged against the new valid.
  // --------------------------------------------------------------------------
  logic       r_load_d;
  logic [6:0] r_value;
  logic       r_valid;
  logic       r_update;
  logic [6:0] w_value_new;
  logic       w_valid_next;

  assign w_value_new  = 7'(r_tens) * 7'd10 + 7'(r_ones);
  assign w_valid_next = !w_to_fire && r_seen_ones && r_seen_tens;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_d <= 1'b0;
      r_value  <= '0;
      r_valid  <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_load_d <= w_cap_legal;
      r_valid  <= w_valid_next;
      if (r_load_d) begin
        r_value <= w_value_new;
      end
      // A first-time valid counts as a change even if the number is equal.
      r_update <= r_load_d && w_valid_next &&
                  (!r_valid || (w_value_new != r_value));
    end
  end

  assign ones_out  = r_ones;
  assign tens_out  = r_tens;
  assign value_out = r_value;
  assign valid     = r_valid;
  assign update    = r_update;
  assign seg_err   = r_seg_err;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_mux_decoder
//  Purpose  : Self-checking bench for seg7_mux_decoder. Expected update
//             events are queued by the stimulus and consumed by a monitor
//             that fires on every update pulse; state checks are directed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_mux_decoder;

  localparam int S  = 4;
  localparam int TO = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [1:0] dig_in;
  logic [3:0] ones_out, tens_out;
  logic [6:0] value_out;
  logic       valid, update, seg_err, timeout;

  seg7_mux_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_in    (dig_in),
    .ones_out  (ones_out),
    .tens_out  (tens_out),
    .value_out (value_out),
    .valid     (valid),
    .update    (update),
    .seg_err   (seg_err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] value;
    logic [3:0] ones;
    logic [3:0] tens;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge and stay for n cycles.
  task automatic drive(input logic [1:0] d, input logic [6:0] s, input int n);
    dig_in = d;
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every update pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && update === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got value %0d expected no pulse", value_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_value", 32'(value_out), 32'(e.value));
        chk("upd_ones",  32'(ones_out),  32'(e.ones));
        chk("upd_tens",  32'(tens_out),  32'(e.tens));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    seg_in = 7'h00;
    dig_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ones",    32'(ones_out),  0);
    chk("rst_tens",    32'(tens_out),  0);
    chk("rst_value",   32'(value_out), 0);
    chk("rst_valid",   32'(valid),     0);
    chk("rst_update",  32'(update),    0);
    chk("rst_seg_err", 32'(seg_err),   0);
    chk("rst_timeout", 32'(timeout),   0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-window: partial window discarded, full latency after release.
    drive(2'b01, 7'h6D, 2);
    pulse_rst();
    chk("midrst_ones",  32'(ones_out),  0);
    chk("midrst_value", 32'(value_out), 0);
    repeat (S + 2) @(negedge clk);
    chk("lat_before", 32'(ones_out), 0);
    @(negedge clk);
    chk("lat_at", 32'(ones_out), 5);

    // Alternating ones 6D / tens 4F, long windows: one update to 35.
    drive(2'b01, 7'h6D, 1024);
    q.push_back('{value: 7'd35, ones: 4'd5, tens: 4'd3});
    drive(2'b10, 7'h4F, 1024);
    drive(2'b01, 7'h6D, 1024);
    drive(2'b10, 7'h4F, 1024);
    chk("alt_ones",  32'(ones_out),  5);
    chk("alt_tens",  32'(tens_out),  3);
    chk("alt_value", 32'(value_out), 35);
    chk("alt_valid", 32'(valid),     1);

    // Ones changes to 4: single update to 34, none on repeated windows.
    q.push_back('{value: 7'd34, ones: 4'd4, tens: 4'd3});
    drive(2'b01, 7'h66, 20);
    drive(2'b10, 7'h4F, 20);
    drive(2'b01, 7'h66, 20);
    chk("chg_value", 32'(value_out), 34);
    chk("chg_ones",  32'(ones_out),  4);

    // Segments toggling every 2 cycles never settle long enough to capture.
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 7'h7F, 2);
      drive(2'b01, 7'h6D, 2);
    end
    drive(2'b00, 7'h00, 20);
    chk("tog_ones",  32'(ones_out),  4);
    chk("tog_tens",  32'(tens_out),  3);
    chk("tog_value", 32'(value_out), 34);

    // Blank pattern in a ones window changes nothing.
    drive(2'b01, 7'h00, 20);
    chk("blank_ones",    32'(ones_out), 4);
    chk("blank_seg_err", 32'(seg_err),  0);
    chk("blank_valid",   32'(valid),    1);

    // Illegal pattern 0x49: sticky error, ones held.
    drive(2'b01, 7'h49, 20);
    chk("bad_seg_err", 32'(seg_err),  1);
    chk("bad_ones",    32'(ones_out), 4);
    drive(2'b00, 7'h00, 50);
    chk("bad_sticky",  32'(seg_err),  1);

    // Illegal strobe 11 held 10 cycles.
    pulse_rst();
    chk("rst2_seg_err", 32'(seg_err), 0);
    chk("rst2_valid",   32'(valid),   0);
    drive(2'b11, 7'h00, 10);
    chk("strobe_seg_err", 32'(seg_err),  1);
    chk("strobe_ones",    32'(ones_out), 0);

    // Timeout and recovery.
    pulse_rst();
    drive(2'b00, 7'h00, 5);
    drive(2'b01, 7'h6D, 20);
    q.push_back('{value: 7'd35, ones: 4'd5, tens: 4'd3});
    drive(2'b10, 7'h4F, 20);
    chk("pre_to_valid", 32'(valid), 1);
    drive(2'b00, 7'h00, 4000);
    chk("to_early",       32'(timeout),   0);
    chk("to_early_valid", 32'(valid),     1);
    drive(2'b00, 7'h00, 200);
    chk("to_flag",  32'(timeout),   1);
    chk("to_valid", 32'(valid),     0);
    chk("to_value", 32'(value_out), 35);
    chk("to_ones",  32'(ones_out),  5);
    drive(2'b10, 7'h7F, S + 2);
    chk("to_before_cap", 32'(timeout), 1);
    drive(2'b10, 7'h7F, 1);
    chk("to_cleared",  32'(timeout),  0);
    chk("rec_tens",    32'(tens_out), 8);
    chk("rec_valid0",  32'(valid),    0);
    drive(2'b10, 7'h7F, 12);
    q.push_back('{value: 7'd81, ones: 4'd1, tens: 4'd8});
    drive(2'b01, 7'h06, 20);
    chk("rec_valid", 32'(valid),     1);
    chk("rec_value", 32'(value_out), 81);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
